alu_spi_slave: RTL and testbench

SPI slave front end for the 4-bit ALU datapath.
- Receives one 16-bit command frame per chip-select window from the external master.
- Decodes the frame into registered operands and opcode that drive the ALU inputs.
- Captures the ALU result and carry.
- Returns them, with status, on MISO during the next frame.
- Sits between the FPGA SPI pins and the combinational ALU.

---
 rtl/alu_spi_pkg.sv | 45 ++++
 rtl/spi_edge_sync.sv | 31 +++
 rtl/alu_spi_slave.sv | 140 ++++++++++++++
 tb/tb_alu_spi_slave.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_spi_pkg.sv
// Shared types and frame layout for the SPI front end of the 4-bit ALU.
package alu_spi_pkg;

    localparam int         FRAME_W  = 16;
    localparam int         CNT_W    = $clog2(FRAME_W) + 1;
    localparam logic [3:0] MISO_TAG = 4'h5;

    // MOSI frame bit positions: {hdr, 2'b00, op, a, b}
    localparam int HDR_MSB = 15;
    localparam int HDR_LSB = 12;
    localparam int PAD_MSB = 11;
    localparam int PAD_LSB = 10;
    localparam int OP_MSB  = 9;
    localparam int OP_LSB  = 8;
    localparam int A_MSB   = 7;
    localparam int A_LSB   = 4;
    localparam int B_MSB   = 3;
    localparam int B_LSB   = 0;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_APPLY,
        ST_CAPTURE,
        ST_WAIT,
        ST_ABORT
    } state_e;

    function automatic logic [FRAME_W-1:0] miso_frame(
        input logic       abort,
        input logic       valid,
        input logic       carry,
        input logic [3:0] result
    );
        return {MISO_TAG, 1'b0, abort, valid, carry, 4'h0, result};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin, with rise/fall pulses.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Resetting low means a pin already low at reset release shows no falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign dout = chain[SYNC_STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/alu_spi_slave.sv
// SPI mode-0 slave that loads ALU operands from a 16-bit frame and returns the result.
// Optional build macro ALU_SPI_HDR_CHECK_EN rejects frames whose header differs from HDR.
module alu_spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] HDR         = 4'hA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_out,
    input  logic       alu_carry,
    output logic       frame_done
);

    import alu_spi_pkg::*;

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_e             state, state_nxt;
    logic [FRAME_W-1:0] shift_in;
    logic [FRAME_W-1:0] miso_sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic [3:0]         result;
    logic               carry, valid, abort;
    logic               cs_armed;
    logic               frame_ok;
    logic [1:0]         pad_unused;

    assign pad_unused = shift_in[PAD_MSB:PAD_LSB];

`ifdef ALU_SPI_HDR_CHECK_EN
    assign frame_ok = (shift_in[HDR_MSB:HDR_LSB] == HDR);
`else
    logic [3:0] hdr_unused;
    assign hdr_unused = shift_in[HDR_MSB:HDR_LSB] ^ HDR;
    assign frame_ok   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // A 16th sclk rise wins over a simultaneous cs_n rise.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (cs_fall) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (sclk_rise && bit_cnt == CNT_W'(FRAME_W - 1)) state_nxt = ST_APPLY;
                else if (cs_rise)                                state_nxt = ST_ABORT;
            end
            ST_APPLY:   state_nxt = frame_ok ? ST_CAPTURE : ST_ABORT;
            ST_CAPTURE: state_nxt = ST_WAIT;
            ST_WAIT:    if (cs_s) state_nxt = ST_IDLE;
            ST_ABORT:   state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Received bits carry no reset state; they are only consumed after 16 fresh shifts.
    always_ff @(posedge clk) begin
        if (state == ST_SHIFT && sclk_rise)
            shift_in <= {shift_in[FRAME_W-2:0], mosi_s};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_sr    <= '0;
            bit_cnt    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            result     <= '0;
            carry      <= 1'b0;
            valid      <= 1'b0;
            abort      <= 1'b0;
            frame_done <= 1'b0;
            cs_armed   <= 1'b0;
        end else begin
            frame_done <= (state == ST_CAPTURE);
            if (cs_rise) cs_armed <= 1'b1;

            if (state == ST_IDLE && cs_fall) begin
                miso_sr <= miso_frame(abort, valid, carry, result);
                bit_cnt <= '0;
            end else if (state != ST_IDLE && sclk_fall) begin
                miso_sr <= {miso_sr[FRAME_W-2:0], 1'b0};
            end

            if (state == ST_SHIFT && sclk_rise)
                bit_cnt <= bit_cnt + CNT_W'(1);

            if (state == ST_APPLY && frame_ok) begin
                alu_op <= shift_in[OP_MSB:OP_LSB];
                alu_a  <= shift_in[A_MSB:A_LSB];
                alu_b  <= shift_in[B_MSB:B_LSB];
            end

            if (state == ST_CAPTURE) begin
                result <= alu_out;
                carry  <= alu_carry;
                valid  <= 1'b1;
                abort  <= 1'b0;
            end

            if (state == ST_ABORT)
                abort <= 1'b1;
        end
    end

    // cs_armed keeps the driver off while cs_n is held low across a reset release.
    assign miso_oe = ~cs_s & cs_armed;
    assign miso    = miso_sr[FRAME_W-1];

endmodule

// File: tb/tb_alu_spi_slave.sv
// Directed bench for alu_spi_slave: SPI master model, behavioural ALU, hand-computed expectations.
module tb_alu_spi_slave;

`ifdef ALU_SPI_HDR_CHECK_EN
    localparam bit HC = 1'b1;
`else
    localparam bit HC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi;
    logic       miso, miso_oe, frame_done, alu_carry;
    logic [3:0] alu_a, alu_b, alu_out;
    logic [1:0] alu_op;
    logic [4:0] alu_sum;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    alu_spi_slave #(.SYNC_STAGES(2), .HDR(4'hA)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_carry(alu_carry), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_sum = '0;
        case (alu_op)
            2'd0: alu_sum = {1'b0, alu_a & alu_b};
            2'd1: alu_sum = {1'b0, alu_a | alu_b};
            2'd2: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            default: alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
        endcase
    end
    assign alu_out   = alu_sum[3:0];
    assign alu_carry = alu_sum[4];

    always @(negedge clk) if (frame_done) done_cnt++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        wait_clk(5);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        wait_clk(5);
        sclk = 1'b1;
        r = miso;
        wait_clk(5);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [23:0] tx, input int nbits, output logic [23:0] rx);
        logic r;
        rx = '0;
        cs_low();
        for (int i = 0; i < nbits; i++) begin
            spi_bit(tx[23-i], r);
            rx = {rx[22:0], r};
        end
        cs_high();
    endtask

    task automatic check_alu(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic [1:0] op);
        check_val({tag, "_a"},  {28'd0, alu_a},  {28'd0, a});
        check_val({tag, "_b"},  {28'd0, alu_b},  {28'd0, b});
        check_val({tag, "_op"}, {30'd0, alu_op}, {30'd0, op});
    endtask

    initial begin
        logic [23:0] rx;
        logic        r;
        int          d0;

        rst_n = 1'b0;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        wait_clk(3);
        check_val("rst_miso", {31'd0, miso}, 32'd0);
        check_val("rst_oe", {31'd0, miso_oe}, 32'd0);
        check_val("rst_done", {31'd0, frame_done}, 32'd0);
        check_alu("rst", 4'h0, 4'h0, 2'd0);
        rst_n = 1'b1;
        wait_clk(10);

        d0 = done_cnt;
        spi_frame({16'h0000, 8'h00}, 16, rx);
        check_val("f1_miso", {16'd0, rx[15:0]}, 32'h5000);
        check_alu("f1", 4'h0, 4'h0, 2'd0);
        check_val("f1_done", done_cnt - d0, HC ? 32'd0 : 32'd1);

        d0 = done_cnt;
        spi_frame({16'hA235, 8'h00}, 16, rx);
        check_val("f2_miso", {16'd0, rx[15:0]}, HC ? 32'h5400 : 32'h5200);
        check_alu("f2", 4'h3, 4'h5, 2'd2);
        check_val("f2_done", done_cnt - d0, 32'd1);

        d0 = done_cnt;
        spi_frame({16'hA2F1, 8'h00}, 16, rx);
        check_val("f3_miso", {16'd0, rx[15:0]}, 32'h5208);
        check_alu("f3", 4'hF, 4'h1, 2'd2);
        check_val("f3_done", done_cnt - d0, 32'd1);

        d0 = done_cnt;
        spi_frame({16'hA235, 8'h00}, 16, rx);
        check_val("f4_miso", {16'd0, rx[15:0]}, 32'h5300);
        check_alu("f4", 4'h3, 4'h5, 2'd2);

        d0 = done_cnt;
        spi_frame({16'hA1FF, 8'h00}, 9, rx);
        check_val("abort_miso9", {23'd0, rx[8:0]}, 32'h0A4);
        check_alu("abort", 4'h3, 4'h5, 2'd2);
        check_val("abort_done", done_cnt - d0, 32'd0);

        d0 = done_cnt;
        spi_frame({16'h3235, 8'h00}, 16, rx);
        check_val("hdr_miso", {16'd0, rx[15:0]}, 32'h5608);
        check_alu("hdr", 4'h3, 4'h5, 2'd2);
        check_val("hdr_done", done_cnt - d0, HC ? 32'd0 : 32'd1);

        d0 = done_cnt;
        rx = '0;
        cs_low();
        for (int i = 0; i < 8; i++) begin
            spi_bit(rx[0] ^ rx[0] ^ (8'hA2 >> (7 - i)) & 1'b1, r);
            rx = {rx[22:0], r};
        end
        check_val("mid_miso8", {24'd0, rx[7:0]}, HC ? 32'h56 : 32'h52);
        rst_n = 1'b0;
        #1;
        check_alu("mid_rst", 4'h0, 4'h0, 2'd0);
        check_val("mid_rst_miso", {31'd0, miso}, 32'd0);
        check_val("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
        check_val("mid_rst_done", {31'd0, frame_done}, 32'd0);
        wait_clk(2);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) spi_bit(((8'h35 >> (7 - i)) & 8'h01) != 8'h00, r);
        check_val("mid_oe_hold", {31'd0, miso_oe}, 32'd0);
        cs_high();
        check_alu("mid_after", 4'h0, 4'h0, 2'd0);
        check_val("mid_done", done_cnt - d0, 32'd0);

        d0 = done_cnt;
        spi_frame({16'hA114, 8'hFF}, 24, rx);
        check_val("long_miso", {8'd0, rx}, 32'h500000);
        check_alu("long", 4'h1, 4'h4, 2'd1);
        check_val("long_done", done_cnt - d0, 32'd1);

        d0 = done_cnt;
        spi_frame({16'hA235, 8'h00}, 16, rx);
        check_val("final_miso", {16'd0, rx[15:0]}, 32'h5205);
        check_val("final_done", done_cnt - d0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
